// File: rtl/udc_ctrl_pkg.sv
// Shared types for the counter bus controller: command ops, FSM states, phase-counter width.
// No logic of its own; imported by udc_bus_ctrl and udc_ctrl_timer.
package udc_ctrl_pkg;

  localparam int PHASE_W = 4;

  typedef enum logic [1:0] {
    OP_WR    = 2'b00,
    OP_RD    = 2'b01,
    OP_START = 2'b10,
    OP_STOP  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_e;

  // Phase lengths are counted down to zero, so the counter is loaded with length-1.
  function automatic logic [PHASE_W-1:0] phase_load(input int cycles);
    return PHASE_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/udc_ctrl_timer.sv
// Loadable phase down-counter; done is high while the count is zero.
// Latency: load takes effect on the next edge. No backpressure.
module udc_ctrl_timer
  import udc_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [PHASE_W-1:0] load_val,
  output logic               done
);

  logic [PHASE_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/udc_bus_ctrl.sv
// Command-to-counter-bus controller: SETUP/STROBE/HOLD cycles on ncs/nwr/nrd, start/stop level control.
// Latency: bus op accepted at T -> rsp_valid at T+SETUP+STROBE+HOLD+1; start/stop -> T+1.
// Backpressure: cmd_ready only in IDLE; no response backpressure. UDC_CTRL_ERR_LATCH_EN makes err_flag sticky.
module udc_bus_ctrl
  import udc_ctrl_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [1:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       ncs,
  output logic       nwr,
  output logic       nrd,
  output logic       a0,
  output logic       a1,
  output logic [7:0] din,
  input  logic [7:0] bus_rdata,
  output logic       start_in,
  input  logic       err_in,
  output logic       err_flag
);

  localparam logic [PHASE_W-1:0] SETUP_LD  = phase_load(SETUP_CYC);
  localparam logic [PHASE_W-1:0] STROBE_LD = phase_load(STROBE_CYC);
  localparam logic [PHASE_W-1:0] HOLD_LD   = phase_load(HOLD_CYC);

  state_e             state_q, state_d;
  logic               tmr_load;
  logic [PHASE_W-1:0] tmr_val;
  logic               tmr_done;
  logic               rd_q;
  logic               accept;
  logic               bus_op;
  op_e                op;

  assign op        = op_e'(cmd_op);
  assign cmd_ready = (state_q == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign bus_op    = (op == OP_WR) || (op == OP_RD);

  udc_ctrl_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      IDLE: begin
        if (accept && bus_op) begin
          state_d  = SETUP;
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
        end
      end
      SETUP: begin
        if (tmr_done) begin
          state_d  = STROBE;
          tmr_load = 1'b1;
          tmr_val  = STROBE_LD;
        end
      end
      STROBE: begin
        if (tmr_done) begin
          state_d  = HOLD;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
      end
      HOLD: begin
        if (tmr_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode straight from the state register, so reset forces them high on the next cycle.
  assign ncs = (state_q == IDLE);
  assign nwr = !((state_q == STROBE) && !rd_q);
  assign nrd = !((state_q == STROBE) && rd_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      rd_q      <= 1'b0;
      a0        <= 1'b0;
      a1        <= 1'b0;
      din       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      start_in  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rsp_valid <= ((state_q == HOLD) && tmr_done) || (accept && !bus_op);
      if (accept && bus_op) begin
        rd_q <= (op == OP_RD);
        a0   <= cmd_addr[0];
        a1   <= cmd_addr[1];
        din  <= cmd_wdata;
      end
      if (accept && (op == OP_START)) start_in <= 1'b1;
      if (accept && (op == OP_STOP))  start_in <= 1'b0;
      if ((state_q == STROBE) && tmr_done && rd_q) begin
        rsp_rdata <= bus_rdata;
      end
    end
  end

`ifdef UDC_CTRL_ERR_LATCH_EN
  // A new error in the same cycle as a stop wins, so no error is lost.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_flag <= 1'b0;
    end else if (err_in) begin
      err_flag <= 1'b1;
    end else if (accept && (op == OP_STOP)) begin
      err_flag <= 1'b0;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_flag <= 1'b0;
    end else begin
      err_flag <= err_in;
    end
  end
`endif

endmodule
